// File: rtl/mux_pkg.sv
// Shared constants, buffer state encoding and select-width helper for the
// registered N:1 multiplexer.
package mux_pkg;

    localparam int MUX_WIDTH = 32;
    localparam int MUX_N     = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // A 2:1 mux still needs one select bit, so never return zero.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_reg_if.sv
// Channel-data / select / handshake bundle between an upstream producer,
// mux_n_reg and its downstream consumer.
interface mux_n_reg_if
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int N     = MUX_N
);
    localparam int SEL_W = sel_w(N);

    logic [N*WIDTH-1:0] d_i;
    logic [SEL_W-1:0]   s_i;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH-1:0]   y_o;
    logic               err_o;
    logic               valid_o;
    logic               ready_i;

    modport slave (
        input  d_i, s_i, valid_i, ready_i,
        output ready_o, y_o, err_o, valid_o
    );

    modport master (
        output d_i, s_i, valid_i, ready_i,
        input  ready_o, y_o, err_o, valid_o
    );

endinterface

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer: registered output stage plus one overflow slot, so
// up_ready is a pure state decode with no path from dn_ready.
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int PW = MUX_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] up_data,
    input  logic          up_valid,
    output logic          up_ready,
    output logic [PW-1:0] dn_data,
    output logic          dn_valid,
    input  logic          dn_ready
);

    buf_state_e    state;
    logic [PW-1:0] main_p1;
    logic [PW-1:0] skid_p1;
    logic          vld_p1;
    logic          rdy_p1;
    logic          accept;
    logic          emit;

    assign accept = up_valid && rdy_p1;
    assign emit   = vld_p1 && dn_ready;

    // ---- stage p1: main register and skid slot ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            main_p1 <= '0;
            skid_p1 <= '0;
            vld_p1  <= 1'b0;
            rdy_p1  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_p1 <= up_data;
                        vld_p1  <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_p1 <= up_data;
                    end else if (accept) begin
                        skid_p1 <= up_data;
                        rdy_p1  <= 1'b0;
                        state   <= FULL;
                    end else if (emit) begin
                        vld_p1  <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    // ready is low here, so only a drain can happen
                    if (emit) begin
                        main_p1 <= skid_p1;
                        rdy_p1  <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    rdy_p1 <= 1'b1;
                    state  <= EMPTY;
                end
            endcase
        end
    end

    assign up_ready = rdy_p1;
    assign dn_data  = main_p1;
    assign dn_valid = vld_p1;

endmodule

// File: rtl/mux_n_reg.sv
// Registered N:1 operand multiplexer with valid/ready handshake.
// Define MUX_N_REG_RANGE_CHECK_EN to flag out-of-range selects on err_o.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int N     = MUX_N
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mux_n_reg_if.slave  bus
);

    localparam int SEL_W = sel_w(N);

    logic [WIDTH-1:0] sel_data_p0;
    logic             err_p0;
    logic [WIDTH:0]   pay_p0;
    logic [WIDTH:0]   pay_p1;
`ifdef MUX_N_REG_RANGE_CHECK_EN
    logic             hit_p0;
`endif

    // ---- stage p0: combinational channel select ----
    always_comb begin
        sel_data_p0 = bus.d_i[0 +: WIDTH];
        err_p0      = 1'b0;
`ifdef MUX_N_REG_RANGE_CHECK_EN
        hit_p0      = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (bus.s_i == SEL_W'(k)) begin
                sel_data_p0 = bus.d_i[k*WIDTH +: WIDTH];
`ifdef MUX_N_REG_RANGE_CHECK_EN
                hit_p0      = 1'b1;
`endif
            end
        end
`ifdef MUX_N_REG_RANGE_CHECK_EN
        if (!hit_p0) begin
            sel_data_p0 = '0;
            err_p0      = 1'b1;
        end
`endif
    end

    assign pay_p0 = {err_p0, sel_data_p0};

    mux_skid_buf #(
        .PW (WIDTH + 1)
    ) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .up_data  (pay_p0),
        .up_valid (bus.valid_i),
        .up_ready (bus.ready_o),
        .dn_data  (pay_p1),
        .dn_valid (bus.valid_o),
        .dn_ready (bus.ready_i)
    );

    assign bus.y_o   = pay_p1[WIDTH-1:0];
    assign bus.err_o = pay_p1[WIDTH];

endmodule
